// File: rtl/spi_pkg.sv
// Shared constants and types for the SPI master peripheral.
package spi_pkg;

  // Register offsets (addr[3:2]).
  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_DATA   = 2'd2;
  localparam logic [1:0] ADDR_RSVD   = 2'd3;

  // CTRL bit positions.
  localparam int CTRL_EN      = 0;
  localparam int CTRL_CPOL    = 1;
  localparam int CTRL_CPHA    = 2;
  localparam int CTRL_SS      = 3;
  localparam int CTRL_IE      = 4;
  localparam int CTRL_DIV_LSB = 8;

  // STATUS bit positions.
  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_OVF  = 2;

  // SCLK edges per 8-bit transfer.
  localparam int EDGES = 16;

  // CTRL reset image; the DIV field is overridden by the RST_DIV parameter.
  localparam logic [31:0] CTRL_RST = 32'h0000_0408;

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} spi_state_e;

endpackage

// File: rtl/spi_shift_engine.sv
// Serialiser: divider, edge counter, TX/RX shift registers and transfer FSM.
module spi_shift_engine import spi_pkg::*; #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       tx_byte,
  input  logic             cpol,
  input  logic             cpha,
  input  logic [DIV_W-1:0] div,
  input  logic             abort,
  input  logic             miso,
  output logic             busy,
  output logic             done,
  output logic [7:0]       rx_byte,
  output logic             sclk,
  output logic             mosi
);

  spi_state_e       state, state_nxt;
  logic [DIV_W-1:0] div_cnt, div_q;
  logic [3:0]       edge_cnt;
  logic             cpha_q;
  logic [7:0]       tx_sr, rx_sr;
  logic             tick, lead;

  // A tick is the terminal count of the half-period divider; even edges are leading.
  assign tick = (state == ST_SHIFT) && (div_cnt == div_q);
  assign lead = ~edge_cnt[0];

  assign busy    = (state != ST_IDLE);
  assign done    = (state == ST_DONE);
  assign rx_byte = rx_sr;
  assign mosi    = (state == ST_SHIFT) ? tx_sr[7] : 1'b1;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; abort always returns to IDLE without a completion.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (start && !abort) state_nxt = ST_SHIFT;
      ST_SHIFT: if (abort) state_nxt = ST_IDLE;
                else if (tick && edge_cnt == 4'(EDGES - 1)) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: mode/divider captured at start, SCLK toggled and data moved on ticks.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt  <= '0;
      div_q    <= '0;
      edge_cnt <= '0;
      cpha_q   <= 1'b0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      sclk     <= 1'b0;
    end else if (state == ST_IDLE || abort) begin
      sclk <= cpol;
      if (state == ST_IDLE && start) begin
        tx_sr    <= tx_byte;
        div_cnt  <= '0;
        edge_cnt <= '0;
        div_q    <= div;
        cpha_q   <= cpha;
      end
    end else if (state == ST_SHIFT) begin
      if (tick) begin
        div_cnt  <= '0;
        sclk     <= ~sclk;
        edge_cnt <= edge_cnt + 4'd1;
        // CPHA=0 samples on leading edges, CPHA=1 on trailing edges.
        if (lead ^ cpha_q) rx_sr <= {rx_sr[6:0], miso};
        // tx[7] is already on MOSI at entry, so CPHA=1 skips the shift on edge 0.
        if (cpha_q ? (lead && edge_cnt != 4'd0) : !lead) tx_sr <= {tx_sr[6:0], 1'b0};
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/spi_master.sv
// Memory-mapped SPI master: register file, bus decode and completion interrupt.
module spi_master import spi_pkg::*; #(
  parameter int               DIV_W   = 8,
  parameter logic [DIV_W-1:0] RST_DIV = DIV_W'(4)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  input  logic [3:0]  sel_i,
  input  logic        we_i,
  output logic [31:0] data_o,
  output logic        irq_o,
  output logic        spi_sclk_o,
  output logic        spi_mosi_o,
  input  logic        spi_miso_i,
  output logic        spi_ss_no
);

  logic             en, cpol, cpha, ss, ie;
  logic [DIV_W-1:0] div;
  logic             st_done, st_ovf;
  logic [7:0]       rx_q, eng_rx;
  logic             eng_busy, eng_done;
  logic             acc_wr, acc_rd, wr_ctrl, wr_stat, wr_data, rd_rx;
  logic             start, ovf_set, done_clr, ovf_clr;
  logic [31:0]      rd_data;
  logic             unused_bits;

  assign unused_bits = ^{addr_i[31:4], addr_i[1:0], data_i[31:16], sel_i[3:2]};

  assign acc_wr  = req_i & we_i;
  assign acc_rd  = req_i & ~we_i;
  assign wr_ctrl = acc_wr && addr_i[3:2] == ADDR_CTRL;
  assign wr_stat = acc_wr && addr_i[3:2] == ADDR_STATUS && sel_i[0];
  assign wr_data = acc_wr && addr_i[3:2] == ADDR_DATA && sel_i[0];
  assign rd_rx   = acc_rd && addr_i[3:2] == ADDR_DATA;

  assign start    = wr_data & en & ~eng_busy;
  assign ovf_set  = wr_data & en & eng_busy;
  assign done_clr = rd_rx | (wr_stat & data_i[STAT_DONE]);
  assign ovf_clr  = wr_stat & data_i[STAT_OVF];

  assign irq_o     = st_done & ie;
  assign spi_ss_no = ss;

  // CTRL register, byte-lane write enables.
  always_ff @(posedge clk) begin
    if (rst) begin
      en   <= CTRL_RST[CTRL_EN];
      cpol <= CTRL_RST[CTRL_CPOL];
      cpha <= CTRL_RST[CTRL_CPHA];
      ss   <= CTRL_RST[CTRL_SS];
      ie   <= CTRL_RST[CTRL_IE];
      div  <= RST_DIV;
    end else if (wr_ctrl) begin
      if (sel_i[0]) begin
        en   <= data_i[CTRL_EN];
        cpol <= data_i[CTRL_CPOL];
        cpha <= data_i[CTRL_CPHA];
        ss   <= data_i[CTRL_SS];
        ie   <= data_i[CTRL_IE];
      end
      if (sel_i[1]) div <= data_i[CTRL_DIV_LSB +: DIV_W];
    end
  end

  // Sticky flags and RX holding register; a new completion beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_done <= 1'b0;
      st_ovf  <= 1'b0;
      rx_q    <= '0;
    end else begin
      if (eng_done)      st_done <= 1'b1;
      else if (done_clr) st_done <= 1'b0;
      if (ovf_set)       st_ovf  <= 1'b1;
      else if (ovf_clr)  st_ovf  <= 1'b0;
      if (eng_done)      rx_q    <= eng_rx;
    end
  end

  // Read mux over the pre-access register values.
  always_comb begin
    rd_data = '0;
    unique case (addr_i[3:2])
      ADDR_CTRL: begin
        rd_data[CTRL_EN]               = en;
        rd_data[CTRL_CPOL]             = cpol;
        rd_data[CTRL_CPHA]             = cpha;
        rd_data[CTRL_SS]               = ss;
        rd_data[CTRL_IE]               = ie;
        rd_data[CTRL_DIV_LSB +: DIV_W] = div;
      end
      ADDR_STATUS: begin
        rd_data[STAT_BUSY] = eng_busy;
        rd_data[STAT_DONE] = st_done;
        rd_data[STAT_OVF]  = st_ovf;
      end
      ADDR_DATA: rd_data[7:0] = rx_q;
      ADDR_RSVD: rd_data = '0;
      default:   rd_data = '0;
    endcase
  end

  // Registered read data, held between reads.
  always_ff @(posedge clk) begin
    if (rst)         data_o <= '0;
    else if (acc_rd) data_o <= rd_data;
  end

  spi_shift_engine #(.DIV_W(DIV_W)) u_eng (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .tx_byte (data_i[7:0]),
    .cpol    (cpol),
    .cpha    (cpha),
    .div     (div),
    .abort   (~en),
    .miso    (spi_miso_i),
    .busy    (eng_busy),
    .done    (eng_done),
    .rx_byte (eng_rx),
    .sclk    (spi_sclk_o),
    .mosi    (spi_mosi_o)
  );

endmodule

// File: tb/tb_spi_master.sv
// Randomised bench for spi_master with a behavioural SPI slave model.
module tb_spi_master;
  import spi_pkg::*;

  logic        clk = 1'b0, rst = 1'b1, req = 1'b0, we = 1'b0;
  logic [31:0] addr = '0, wdata = '0, data_o;
  logic [3:0]  sel = '0;
  logic        irq_o, sclk, mosi, miso, ss_n;

  int n_vec = 0, n_err = 0;

  // Slave model state: edges counted from 0 since the transfer was armed.
  logic [7:0] slv_tx = '0, slv_rx = '0;
  int         slv_edges = 0;
  bit         slv_on = 0, slv_cpha = 0, loopback = 0;

  bit          r_cpol, r_cpha, r_ie;
  int          r_div;
  logic [31:0] rd;

  always #5 clk = ~clk;

  spi_master #(.DIV_W(8), .RST_DIV(8'd4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_i      (req),
    .addr_i     (addr),
    .data_i     (wdata),
    .sel_i      (sel),
    .we_i       (we),
    .data_o     (data_o),
    .irq_o      (irq_o),
    .spi_sclk_o (sclk),
    .spi_mosi_o (mosi),
    .spi_miso_i (miso),
    .spi_ss_no  (ss_n)
  );

  assign miso = loopback ? mosi : slv_tx[7];

  // SPI slave: samples MOSI on the capture edge of the mode, changes MISO on the other.
  always @(sclk) begin
    if (slv_on) begin
      if (((slv_edges % 2) == 0) != slv_cpha) slv_rx = {slv_rx[6:0], mosi};
      else if (slv_edges != 0)                 slv_tx = {slv_tx[6:0], 1'b0};
      slv_edges++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, act, exp);
    end
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] s);
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = {28'd0, a, 2'b00}; wdata = d; sel = s;
    @(negedge clk);
    req = 1'b0; we = 1'b0;
  endtask

  task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = {28'd0, a, 2'b00}; sel = 4'hF;
    @(negedge clk);
    req = 1'b0;
    d = data_o;
  endtask

  // One transfer: STATUS is polled every cycle to measure BUSY, optionally
  // with a second DATA write injected at poll index ovf_at.
  task automatic run_xfer(input logic [7:0] tx, input logic [7:0] sb, input bit lb,
                          input bit cpha, input int div, input bit ie, input int ovf_at);
    int          cnt = 0;
    bit          fin = 0;
    logic [31:0] st, r;
    @(negedge clk);
    slv_tx = sb; slv_rx = '0; slv_edges = 0; slv_cpha = cpha; loopback = lb; slv_on = 1;
    req = 1'b1; we = 1'b1; addr = {28'd0, ADDR_DATA, 2'b00}; wdata = {24'd0, tx}; sel = 4'h1;
    @(negedge clk);
    we = 1'b0; addr = {28'd0, ADDR_STATUS, 2'b00};
    for (int i = 0; i < 2000 && !fin; i++) begin
      @(negedge clk);
      if (data_o[STAT_BUSY]) cnt++;
      else if (cnt > 0) fin = 1;
      if (!fin && i == ovf_at) begin
        we = 1'b1; addr = {28'd0, ADDR_DATA, 2'b00}; wdata = 32'h55;
      end else begin
        we = 1'b0; addr = {28'd0, ADDR_STATUS, 2'b00};
      end
    end
    st = data_o; req = 1'b0; we = 1'b0; slv_on = 0;
    chk("busy_cycles", cnt, 16 * (div + 1) + 1);
    chk("status_end", {29'd0, st[2:0]}, {29'd0, (ovf_at >= 0), 2'b10});
    chk("irq_done", {31'd0, irq_o}, {31'd0, ie});
    chk("mosi_bits", {24'd0, slv_rx}, {24'd0, tx});
    if (ovf_at >= 0) begin
      bus_wr(ADDR_STATUS, 32'h6, 4'h1);
      bus_rd(ADDR_STATUS, r);
      chk("w1c_clear", r, 32'h0);
    end
    bus_rd(ADDR_DATA, r);
    chk("rx_byte", r, {24'd0, lb ? tx : sb});
    bus_rd(ADDR_STATUS, r);
    chk("done_rd_clr", r, 32'h0);
    chk("irq_clr", {31'd0, irq_o}, 32'h0);
  endtask

  initial begin
    // Reset state.
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_sclk", {31'd0, sclk}, 32'h0);
    chk("rst_ss", {31'd0, ss_n}, 32'h1);
    chk("rst_mosi", {31'd0, mosi}, 32'h1);
    chk("rst_irq", {31'd0, irq_o}, 32'h0);
    bus_rd(ADDR_CTRL, rd);   chk("rst_ctrl", rd, 32'h0000_0408);
    bus_rd(ADDR_STATUS, rd); chk("rst_status", rd, 32'h0);

    // Mode 0, DIV=0, loopback, interrupt enabled.
    bus_wr(ADDR_CTRL, 32'h0000_0011, 4'hF);
    chk("ss_low", {31'd0, ss_n}, 32'h0);
    run_xfer(8'hA5, 8'h00, 1, 0, 0, 1, -1);

    // Mode 3, DIV=3.
    bus_wr(ADDR_CTRL, 32'h0000_0307, 4'hF);
    @(negedge clk);
    chk("sclk_idle_cpol1", {31'd0, sclk}, 32'h1);
    run_xfer(8'h81, 8'h3C, 0, 1, 3, 0, -1);

    // Overlapping DATA write while busy.
    run_xfer(8'hC3, 8'h5A, 0, 1, 3, 0, 10);

    // Random modes, dividers and bytes.
    for (int k = 0; k < 8; k++) begin
      r_cpol = 1'($urandom_range(0, 1));
      r_cpha = 1'($urandom_range(0, 1));
      r_ie   = 1'($urandom_range(0, 1));
      r_div  = int'($urandom_range(0, 3));
      bus_wr(ADDR_CTRL, {16'd0, 8'(r_div), 3'b000, r_ie, 1'b0, r_cpha, r_cpol, 1'b1}, 4'h3);
      run_xfer(8'($urandom), 8'($urandom), 0, r_cpha, r_div, r_ie,
               (k % 3 == 1) ? int'($urandom_range(3, 12)) : -1);
    end

    // Abort by clearing EN just after edge 8 (CPOL=1, DIV=3).
    bus_wr(ADDR_CTRL, 32'h0000_0303, 4'h3);
    @(negedge clk);
    slv_tx = '0; slv_rx = '0; slv_edges = 0; slv_cpha = 0; loopback = 0; slv_on = 1;
    bus_wr(ADDR_DATA, 32'h96, 4'h1);
    for (int i = 0; i < 1000 && slv_edges < 9; i++) @(negedge clk);
    slv_on = 0;
    chk("abort_edge8", slv_edges, 9);
    bus_wr(ADDR_CTRL, 32'h0000_0302, 4'h3);
    bus_rd(ADDR_STATUS, rd); chk("abort_status", rd, 32'h0);
    chk("abort_sclk", {31'd0, sclk}, 32'h1);
    repeat (80) @(negedge clk);
    bus_rd(ADDR_STATUS, rd); chk("abort_no_done", rd, 32'h0);

    // Reset in the middle of a mode 3 transfer.
    bus_wr(ADDR_CTRL, 32'h0000_0317, 4'hF);
    bus_wr(ADDR_DATA, 32'hE7, 4'h1);
    repeat (6) @(negedge clk);
    bus_rd(ADDR_CTRL, rd); chk("ctrl_rb", rd, 32'h0000_0317);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_sclk", {31'd0, sclk}, 32'h0);
    chk("mrst_ss", {31'd0, ss_n}, 32'h1);
    chk("mrst_mosi", {31'd0, mosi}, 32'h1);
    chk("mrst_irq", {31'd0, irq_o}, 32'h0);
    chk("mrst_data_o", data_o, 32'h0);
    bus_rd(ADDR_CTRL, rd);   chk("mrst_ctrl", rd, 32'h0000_0408);
    bus_rd(ADDR_STATUS, rd); chk("mrst_status", rd, 32'h0);

    // Byte-lane CTRL write, then DATA write with EN=0, then reserved slot.
    bus_wr(ADDR_CTRL, 32'h0000_0200, 4'b0010);
    bus_rd(ADDR_CTRL, rd); chk("ctrl_sel1", rd, 32'h0000_0208);
    bus_wr(ADDR_DATA, 32'h5A, 4'h1);
    bus_rd(ADDR_STATUS, rd); chk("en0_status", rd, 32'h0);
    chk("en0_mosi", {31'd0, mosi}, 32'h1);
    bus_wr(ADDR_RSVD, 32'hFFFF_FFFF, 4'hF);
    bus_rd(ADDR_RSVD, rd); chk("rsvd_rd", rd, 32'h0);
    bus_rd(ADDR_CTRL, rd); chk("rsvd_no_side", rd, 32'h0000_0208);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
